// File: rtl/video_ram_arbiter.sv
// Shares a single-port video RAM between a graphics reader (always wins) and a
// packet writer that is buffered in a small FIFO and drained on idle cycles.
module video_ram_arbiter #(
  parameter int unsigned RAM_SIZE    = 1024,
  parameter int unsigned COLOR_LEN   = 12,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned RAM_LATENCY = 2,
  localparam int unsigned AW = $clog2(RAM_SIZE),
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rd_req,
  input  logic [AW-1:0]        rd_addr,
  output logic                 rd_ready,
  output logic [COLOR_LEN-1:0] rd_val,
  input  logic                 wr_valid,
  input  logic [AW-1:0]        wr_addr,
  input  logic [COLOR_LEN-1:0] wr_data,
  output logic                 wr_ready,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [AW-1:0]        ram_addr,
  output logic [COLOR_LEN-1:0] ram_din,
  input  logic [COLOR_LEN-1:0] ram_dout,
  output logic [CW-1:0]        fifo_count
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  logic [AW-1:0]          addr_mem_q [FIFO_DEPTH];
  logic [COLOR_LEN-1:0]   data_mem_q [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [RAM_LATENCY-1:0] rd_pipe_q, rd_pipe_d;
  logic                   fifo_nonempty;
  logic                   push;
  logic                   pop;

  // Handshake and arbitration depend only on registered state and rd_req.
  assign fifo_nonempty = (count_q != '0);
  assign wr_ready      = (count_q != CW'(FIFO_DEPTH));
  assign push          = wr_valid && wr_ready;
  assign pop           = !rd_req && fifo_nonempty;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_pipe_d = RAM_LATENCY'({rd_pipe_q, rd_req});
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_pipe_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_pipe_q <= rd_pipe_d;
    end
  end

  // FIFO storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[wr_ptr_q] <= wr_addr;
      data_mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign ram_en     = rd_req || fifo_nonempty;
  assign ram_we     = !rd_req && fifo_nonempty;
  assign ram_addr   = rd_req ? rd_addr : addr_mem_q[rd_ptr_q];
  assign ram_din    = data_mem_q[rd_ptr_q];
  assign rd_ready   = rd_pipe_q[RAM_LATENCY-1];
  assign rd_val     = rd_ready ? ram_dout : '0;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_video_ram_arbiter.sv
// Bench for video_ram_arbiter: behavioural RAM plus a queue-based reference
// model of the write FIFO, read scoreboard and expected RAM contents.
module tb_video_ram_arbiter;
  localparam int AW = 10, CL = 12, DEPTH = 8, LAT = 2, CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_req, wr_valid;
  logic [AW-1:0] rd_addr, wr_addr, ram_addr;
  logic [CL-1:0] wr_data, rd_val, ram_din, ram_dout;
  logic          rd_ready, wr_ready, ram_en, ram_we;
  logic [CW-1:0] fifo_count;

  video_ram_arbiter #(.RAM_SIZE(1024), .COLOR_LEN(CL), .FIFO_DEPTH(DEPTH), .RAM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_val(rd_val), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout), .fifo_count(fifo_count));

  always #5 clk = ~clk;

  // Single-port RAM with a LAT-stage registered read path.
  logic [CL-1:0] mem   [1024];
  logic [CL-1:0] rpipe [LAT];
  assign ram_dout = rpipe[LAT-1];
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) rpipe[i] <= rpipe[i-1];
    if (ram_en && ram_we) mem[ram_addr] <= ram_din;
    rpipe[0] <= (ram_en && !ram_we) ? mem[ram_addr] : '0;
  end

  typedef struct packed { logic [AW-1:0] a; logic [CL-1:0] d; } wr_t;
  typedef struct packed { int due; logic [CL-1:0] d; } rd_t;
  wr_t           fq[$];
  rd_t           rq[$];
  logic [CL-1:0] ref_mem [1024];
  int            cyc, n_vec, n_miss;

  logic          e_wrdy, e_en, e_we, e_rdy;
  logic [CW-1:0] e_cnt;
  logic [AW-1:0] e_addr;
  logic [CL-1:0] e_din, e_val;

  // Apply inputs for this cycle and form the model's expectations.
  task automatic drive(input logic r, input logic [AW-1:0] ra, input logic w,
                       input logic [AW-1:0] wa, input logic [CL-1:0] wd);
    rd_req = r; rd_addr = ra; wr_valid = w; wr_addr = wa; wr_data = wd;
    #1;
    e_cnt  = CW'(fq.size());
    e_wrdy = fq.size() < DEPTH;
    e_en   = r || fq.size() > 0;
    e_we   = !r && fq.size() > 0;
    e_addr = r ? ra : (fq.size() > 0 ? fq[0].a : '0);
    e_din  = fq.size() > 0 ? fq[0].d : '0;
    e_rdy  = rq.size() > 0 && rq[0].due == cyc;
    e_val  = e_rdy ? rq[0].d : '0;
  endtask

  // Advance one clock and update the model the same way the RAM sees traffic.
  task automatic tick();
    bit  do_pop, do_push;
    rd_t r;
    wr_t w;
    do_pop  = !rd_req && fq.size() > 0;
    do_push = wr_valid && fq.size() < DEPTH;
    @(posedge clk);
    if (!rst) begin
      fq.delete(); rq.delete();
    end else begin
      if (rq.size() > 0 && rq[0].due == cyc) void'(rq.pop_front());
      if (rd_req) begin r.due = cyc + LAT; r.d = ref_mem[rd_addr]; rq.push_back(r); end
      if (do_pop) begin ref_mem[fq[0].a] = fq[0].d; void'(fq.pop_front()); end
      if (do_push) begin w.a = wr_addr; w.d = wr_data; fq.push_back(w); end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(0, '0, 0, '0, '0);
      n_vec++; if (wr_ready !== 1'b1) begin n_miss++; $display("FAIL reset wr_ready got %b want 1", wr_ready); end
      n_vec++; if (fifo_count !== '0) begin n_miss++; $display("FAIL reset count got %0d want 0", fifo_count); end
      n_vec++; if (ram_en !== 1'b0) begin n_miss++; $display("FAIL reset ram_en got %b want 0", ram_en); end
      n_vec++; if (rd_ready !== 1'b0 || rd_val !== '0) begin n_miss++; $display("FAIL reset rd got %b/%h want 0/0", rd_ready, rd_val); end
      tick();
    end
    rst = 1'b1;
  endtask

  task automatic test_read_latency();
    mem[37] = 12'hABC; ref_mem[37] = 12'hABC;
    for (int i = 0; i < 6; i++) begin
      drive(i == 0, AW'(37), 0, '0, '0);
      n_vec++; if (rd_ready !== (i == 2)) begin n_miss++; $display("FAIL lat rd_ready i=%0d got %b want %b", i, rd_ready, i == 2); end
      n_vec++; if (rd_val !== (i == 2 ? 12'hABC : 12'h000)) begin n_miss++; $display("FAIL lat rd_val i=%0d got %h", i, rd_val); end
      tick();
    end
  endtask

  task automatic test_fill_stall();
    logic [AW-1:0] wa [10];
    logic [CL-1:0] wd [10];
    int k = 0, j = 0;
    bit acc;
    for (int i = 0; i < 10; i++) begin wa[i] = AW'(100 + i); wd[i] = CL'($urandom); end
    for (int i = 0; i < 12; i++) begin
      drive(1, '0, k < 10, k < 10 ? wa[k] : '0, k < 10 ? wd[k] : '0);
      n_vec++; if (ram_we !== 1'b0) begin n_miss++; $display("FAIL fill ram_we got %b want 0", ram_we); end
      n_vec++; if (fifo_count !== e_cnt) begin n_miss++; $display("FAIL fill count got %0d want %0d", fifo_count, e_cnt); end
      acc = wr_valid && e_wrdy;
      tick();
      if (acc) k++;
    end
    drive(0, '0, 1, wa[k], wd[k]);
    n_vec++; if (wr_ready !== 1'b0 || fifo_count !== CW'(8)) begin n_miss++; $display("FAIL full got rdy=%b cnt=%0d want 0/8", wr_ready, fifo_count); end
    for (int i = 0; i < 14; i++) begin
      if (i > 0) drive(0, '0, k < 10, k < 10 ? wa[k] : '0, k < 10 ? wd[k] : '0);
      n_vec++; if (ram_we !== e_we) begin n_miss++; $display("FAIL drain ram_we i=%0d got %b want %b", i, ram_we, e_we); end
      if (ram_we === 1'b1 && j < 10) begin
        n_vec++; if (ram_addr !== wa[j] || ram_din !== wd[j]) begin n_miss++; $display("FAIL drain order j=%0d got %0d/%h want %0d/%h", j, ram_addr, ram_din, wa[j], wd[j]); end
        j++;
      end
      acc = wr_valid && e_wrdy;
      tick();
      if (acc) k++;
    end
    n_vec++; if (j !== 10) begin n_miss++; $display("FAIL drain writes got %0d want 10", j); end
  endtask

  task automatic test_stream();
    logic [CL-1:0] sd [20];
    for (int i = 0; i < 20; i++) begin
      sd[i] = CL'($urandom);
      drive(0, '0, 1, AW'(200 + i), sd[i]);
      n_vec++; if (fifo_count !== (i == 0 ? CW'(0) : CW'(1))) begin n_miss++; $display("FAIL stream count i=%0d got %0d", i, fifo_count); end
      n_vec++; if (ram_we !== e_we) begin n_miss++; $display("FAIL stream ram_we i=%0d got %b want %b", i, ram_we, e_we); end
      if (e_we) begin
        n_vec++; if (ram_addr !== e_addr || ram_din !== e_din) begin n_miss++; $display("FAIL stream wr got %0d/%h want %0d/%h", ram_addr, ram_din, e_addr, e_din); end
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin drive(0, '0, 0, '0, '0); tick(); end
    for (int i = 0; i < 20; i++) begin
      n_vec++; if (mem[200 + i] !== sd[i]) begin n_miss++; $display("FAIL stream mem[%0d] got %h want %h", 200 + i, mem[200 + i], sd[i]); end
    end
  endtask

  task automatic test_no_forward();
    mem[5] = 12'h5A5; ref_mem[5] = 12'h5A5;
    drive(1, '0, 1, AW'(5), 12'h111); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, i == 0 ? AW'(5) : '0, 0, '0, '0);
      if (i == 2) begin
        n_vec++; if (rd_ready !== 1'b1 || rd_val !== 12'h5A5) begin n_miss++; $display("FAIL nofwd old got %b/%h want 1/5a5", rd_ready, rd_val); end
      end
      tick();
    end
    for (int i = 0; i < 2; i++) begin drive(0, '0, 0, '0, '0); tick(); end
    drive(1, AW'(5), 0, '0, '0); tick();
    drive(0, '0, 0, '0, '0); tick();
    drive(0, '0, 0, '0, '0);
    n_vec++; if (rd_ready !== 1'b1 || rd_val !== 12'h111) begin n_miss++; $display("FAIL nofwd new got %b/%h want 1/111", rd_ready, rd_val); end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 2) == 0, AW'($urandom_range(0, 15)), $urandom_range(0, 9) < 7,
            AW'($urandom_range(0, 15)), CL'($urandom));
      n_vec++; if (wr_ready !== e_wrdy) begin n_miss++; $display("FAIL rand wr_ready c=%0d got %b want %b", cyc, wr_ready, e_wrdy); end
      n_vec++; if (fifo_count !== e_cnt) begin n_miss++; $display("FAIL rand count c=%0d got %0d want %0d", cyc, fifo_count, e_cnt); end
      n_vec++; if (ram_en !== e_en || ram_we !== e_we) begin n_miss++; $display("FAIL rand en/we c=%0d got %b%b want %b%b", cyc, ram_en, ram_we, e_en, e_we); end
      n_vec++; if (rd_ready !== e_rdy || rd_val !== e_val) begin n_miss++; $display("FAIL rand rd c=%0d got %b/%h want %b/%h", cyc, rd_ready, rd_val, e_rdy, e_val); end
      if (e_en) begin
        n_vec++; if (ram_addr !== e_addr) begin n_miss++; $display("FAIL rand addr c=%0d got %0d want %0d", cyc, ram_addr, e_addr); end
      end
      if (e_we) begin
        n_vec++; if (ram_din !== e_din) begin n_miss++; $display("FAIL rand din c=%0d got %h want %h", cyc, ram_din, e_din); end
      end
      tick();
    end
    for (int i = 0; i < DEPTH + 3; i++) begin drive(0, '0, 0, '0, '0); tick(); end
  endtask

  task automatic test_reset_inflight();
    for (int i = 0; i < 4; i++) begin
      mem[300 + i] = '0; ref_mem[300 + i] = '0;
      drive(1, AW'($urandom_range(0, 15)), 1, AW'(300 + i), 12'h800 | CL'(i));
      tick();
    end
    fq.delete(); rq.delete();
    rst = 1'b0;
    drive(0, '0, 0, '0, '0);
    n_vec++; if (fifo_count !== '0 || wr_ready !== 1'b1) begin n_miss++; $display("FAIL rstfl fifo got %0d/%b want 0/1", fifo_count, wr_ready); end
    n_vec++; if (ram_en !== 1'b0 || ram_we !== 1'b0) begin n_miss++; $display("FAIL rstfl ram got %b%b want 00", ram_en, ram_we); end
    n_vec++; if (rd_ready !== 1'b0 || rd_val !== '0) begin n_miss++; $display("FAIL rstfl rd got %b/%h want 0/0", rd_ready, rd_val); end
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(0, '0, 0, '0, '0);
      n_vec++; if (ram_we !== 1'b0 || rd_ready !== 1'b0) begin n_miss++; $display("FAIL postrst i=%0d got we=%b rdy=%b want 0/0", i, ram_we, rd_ready); end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (mem[300 + i] !== '0) begin n_miss++; $display("FAIL postrst mem[%0d] got %h want 000", 300 + i, mem[300 + i]); end
    end
  endtask

  initial begin
    int bad;
    n_vec = 0; n_miss = 0; cyc = 0;
    for (int i = 0; i < 1024; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    for (int i = 0; i < LAT; i++) rpipe[i] = '0;
    rst = 1'b0; rd_req = 0; rd_addr = '0; wr_valid = 0; wr_addr = '0; wr_data = '0;
    @(negedge clk);
    test_reset();
    test_read_latency();
    test_fill_stall();
    test_stream();
    test_no_forward();
    test_random();
    test_reset_inflight();
    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
    n_vec++; if (bad != 0) begin n_miss++; $display("FAIL final mem got %0d differing words want 0", bad); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
